// File: rtl/serial_alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_alu_seq_if
// Purpose  : Request/response bundle between an operand source and serial_alu_seq.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;
  logic             err;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, overflow, zero, err
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, overflow, zero, err
  );
endinterface
`default_nettype wire

// File: rtl/serial_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : serial_alu_seq
// Purpose  : Digit-serial ADD/SUB/AND/OR/XOR unit, DIGIT bits per cycle with
//            start/busy/done handshake. Optional macro ALU_SAT_EN enables
//            signed saturation of overflowing ADD/SUB results.
// Revision : 1.0 - initial release
// ============================================================================
module serial_alu_seq #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  serial_alu_seq_if.slave   bus
);

  localparam int c_ndig = WIDTH / DIGIT;
  localparam int c_cw   = (c_ndig > 1) ? $clog2(c_ndig) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(c_ndig - 1);

  localparam logic [2:0] c_op_add = 3'b000;
  localparam logic [2:0] c_op_sub = 3'b001;
  localparam logic [2:0] c_op_and = 3'b010;
  localparam logic [2:0] c_op_or  = 3'b011;
  localparam logic [2:0] c_op_xor = 3'b100;

`ifdef ALU_SAT_EN
  localparam logic [WIDTH-1:0] c_sat_neg = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] c_sat_pos = ~c_sat_neg;
`endif

  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
    $error("serial_alu_seq: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic [2:0]       r_op;
  logic             r_carry;
  logic [c_cw-1:0]  r_cnt;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_err;

  logic [DIGIT-1:0] w_bd;
  logic [DIGIT-1:0] w_sum;
  logic [DIGIT-1:0] w_digit;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_final;
  logic             w_cin_msb;
  logic             w_cout_dig;
  logic             w_ovf;
  logic             w_arith;
  logic             w_reserved;
  logic             w_last;

  assign w_arith    = (r_op == c_op_add) || (r_op == c_op_sub);
  assign w_reserved = (r_op > c_op_xor);
  assign w_last     = (r_cnt == c_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Ripple across one digit; the carry entering the digit's top bit is kept
  // because on the final digit it is the carry into the word MSB.
  always_comb begin : p_digit
    logic v_rc;
    w_bd       = (r_op == c_op_sub) ? ~r_b[DIGIT-1:0] : r_b[DIGIT-1:0];
    w_sum      = '0;
    w_cin_msb  = r_carry;
    v_rc       = r_carry;
    for (int i = 0; i < DIGIT; i++) begin
      w_sum[i] = r_a[i] ^ w_bd[i] ^ v_rc;
      if (i == DIGIT - 1) w_cin_msb = v_rc;
      v_rc = (r_a[i] & w_bd[i]) | (v_rc & (r_a[i] ^ w_bd[i]));
    end
    w_cout_dig = v_rc;
    w_ovf      = w_cin_msb ^ w_cout_dig;
    case (r_op)
      c_op_add, c_op_sub: w_digit = w_sum;
      c_op_and:           w_digit = r_a[DIGIT-1:0] & r_b[DIGIT-1:0];
      c_op_or:            w_digit = r_a[DIGIT-1:0] | r_b[DIGIT-1:0];
      c_op_xor:           w_digit = r_a[DIGIT-1:0] ^ r_b[DIGIT-1:0];
      default:            w_digit = '0;
    endcase
  end

  // New digit enters at the top; after the last digit the word is in order.
  assign w_acc_next = WIDTH'({w_digit, r_acc} >> DIGIT);

  always_comb begin
    w_final = w_acc_next;
`ifdef ALU_SAT_EN
    if (w_arith && w_ovf) begin
      w_final = w_cin_msb ? c_sat_pos : c_sat_neg;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_op     <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b1;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_op    <= bus.op;
            r_carry <= (bus.op == c_op_sub);
            r_cnt   <= '0;
            r_acc   <= '0;
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_next;
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_carry <= w_cout_dig;
          r_cnt   <= r_cnt + c_cw'(1);
          if (w_last) begin
            r_result <= w_final;
            r_cout   <= w_arith & w_cout_dig;
            r_ovf    <= w_arith & w_ovf;
            r_zero   <= (w_final == '0);
            r_err    <= w_reserved;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = (r_state == S_DONE);
  assign bus.result   = r_result;
  assign bus.cout     = r_cout;
  assign bus.overflow = r_ovf;
  assign bus.zero     = r_zero;
  assign bus.err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_serial_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_alu_seq
// Purpose  : Directed self-checking bench for serial_alu_seq (WIDTH=16, DIGIT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_alu_seq;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  serial_alu_seq_if #(.WIDTH(16)) bus ();

  serial_alu_seq #(.WIDTH(16), .DIGIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op at a falling edge; lat = falling edges until done (-1 if none).
  task automatic run_op(input logic [2:0] t_op, input logic [15:0] t_a, input logic [15:0] t_b,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    bus.op    = t_op;
    bus.a     = t_a;
    bus.b     = t_b;
    bus.start = 1'b1;
    lat       = -1;
    busy_cnt  = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.result !== 16'h0000) begin errors++; $display("FAIL reset_result: got %h expected 0000", bus.result); end
    checks++; if ({bus.cout, bus.overflow, bus.zero, bus.err} !== 4'b0010) begin
      errors++; $display("FAIL reset_flags: got c/v/z/e=%b expected 0010", {bus.cout, bus.overflow, bus.zero, bus.err});
    end
  endtask

  task automatic test_add;
    int lat, bc;
    run_op(3'b000, 16'd7, 16'd3, lat, bc);
    checks++; if (lat !== 5) begin errors++; $display("FAIL add_latency: got %0d expected 5", lat); end
    checks++; if (bc !== 5) begin errors++; $display("FAIL add_busy_cycles: got %0d expected 5", bc); end
    checks++; if (bus.result !== 16'd10) begin errors++; $display("FAIL add_result: got %h expected 000a", bus.result); end
    checks++; if ({bus.cout, bus.overflow, bus.zero} !== 3'b000) begin
      errors++; $display("FAIL add_flags: got c/v/z=%b expected 000", {bus.cout, bus.overflow, bus.zero});
    end
    @(negedge clk);
    checks++; if ({bus.busy, bus.done} !== 2'b00) begin errors++; $display("FAIL add_after_done: got busy/done=%b expected 00", {bus.busy, bus.done}); end
    checks++; if (bus.result !== 16'd10) begin errors++; $display("FAIL add_hold: got %h expected 000a", bus.result); end
  endtask

  task automatic test_sub;
    int lat, bc;
    run_op(3'b001, 16'd5, 16'd1, lat, bc);
    checks++; if ({bus.result, bus.cout} !== {16'd4, 1'b1}) begin
      errors++; $display("FAIL sub_5_1: got %h cout %b expected 0004 cout 1", bus.result, bus.cout);
    end
    run_op(3'b001, 16'd1, 16'd5, lat, bc);
    checks++; if ({bus.result, bus.cout, bus.zero} !== {16'hFFFC, 1'b0, 1'b0}) begin
      errors++; $display("FAIL sub_1_5: got %h cout %b zero %b expected fffc cout 0 zero 0", bus.result, bus.cout, bus.zero);
    end
    run_op(3'b001, 16'h1234, 16'h1234, lat, bc);
    checks++; if ({bus.result, bus.cout, bus.zero, bus.overflow} !== {16'h0000, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sub_equal: got %h c/z/v %b%b%b expected 0000 110", bus.result, bus.cout, bus.zero, bus.overflow);
    end
  endtask

  task automatic test_overflow;
    int lat, bc;
    logic [15:0] exp_res;
`ifdef ALU_SAT_EN
    exp_res = 16'h7FFF;
`else
    exp_res = 16'h8000;
`endif
    run_op(3'b000, 16'h7FFF, 16'h0001, lat, bc);
    checks++; if ({bus.overflow, bus.cout} !== 2'b10) begin
      errors++; $display("FAIL ovf_flags: got v/c=%b expected 10", {bus.overflow, bus.cout});
    end
    checks++; if (bus.result !== exp_res) begin errors++; $display("FAIL ovf_result: got %h expected %h", bus.result, exp_res); end
  endtask

  task automatic test_logic;
    int lat, bc;
    run_op(3'b100, 16'd23, 16'd101, lat, bc);
    checks++; if ({bus.result, bus.cout, bus.overflow} !== {16'h0072, 2'b00}) begin
      errors++; $display("FAIL xor: got %h c/v %b%b expected 0072 00", bus.result, bus.cout, bus.overflow);
    end
    run_op(3'b010, 16'd23, 16'd101, lat, bc);
    checks++; if (bus.result !== 16'h0005) begin errors++; $display("FAIL and: got %h expected 0005", bus.result); end
    run_op(3'b011, 16'd23, 16'd101, lat, bc);
    checks++; if (bus.result !== 16'h0077) begin errors++; $display("FAIL or: got %h expected 0077", bus.result); end
  endtask

  task automatic test_reserved;
    int lat, bc;
    run_op(3'b110, 16'hABCD, 16'h1234, lat, bc);
    checks++; if (lat !== 5) begin errors++; $display("FAIL rsv_latency: got %0d expected 5", lat); end
    checks++; if ({bus.result, bus.err, bus.cout, bus.overflow, bus.zero} !== {16'h0000, 4'b1001}) begin
      errors++; $display("FAIL rsv_out: got %h e/c/v/z %b%b%b%b expected 0000 1001", bus.result, bus.err, bus.cout, bus.overflow, bus.zero);
    end
    @(negedge clk);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL rsv_err_hold: got %b expected 1", bus.err); end
  endtask

  task automatic test_inflight;
    int ndone;
    logic [15:0] res;
    logic e;
    ndone = 0; res = '0; e = 1'b1;
    @(negedge clk);
    bus.op = 3'b000; bus.a = 16'h0100; bus.b = 16'h0023; bus.start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) begin bus.op = 3'b100; bus.a = 16'hFFFF; bus.b = 16'hFFFF; end
      if (i == 4) bus.start = 1'b0;
      if (bus.done) begin ndone++; res = bus.result; e = bus.err; end
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL inflight_done_count: got %0d expected 1", ndone); end
    checks++; if ({res, e} !== {16'h0123, 1'b0}) begin errors++; $display("FAIL inflight_result: got %h err %b expected 0123 err 0", res, e); end
  endtask

  task automatic test_back_to_back;
    int d1, d2, nd;
    d1 = -1; d2 = -1; nd = 0;
    @(negedge clk);
    bus.op = 3'b000; bus.a = 16'd2; bus.b = 16'd3; bus.start = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 12) bus.start = 1'b0;
      if (bus.done) begin
        nd++;
        if (d1 < 0) d1 = i; else d2 = i;
      end
    end
    checks++; if ({d1, d2, nd} !== {32'sd5, 32'sd11, 32'sd2}) begin
      errors++; $display("FAIL b2b_done_cycles: got %0d,%0d (n=%0d) expected 5,11 (n=2)", d1, d2, nd);
    end
    @(negedge clk);
    checks++; if ({bus.busy, bus.result} !== {1'b0, 16'd5}) begin
      errors++; $display("FAIL b2b_idle: got busy %b result %h expected 0 0005", bus.busy, bus.result);
    end
  endtask

  task automatic test_reset_midop;
    int nd, lat, bc;
    nd = 0;
    @(negedge clk);
    bus.op = 3'b000; bus.a = 16'h0F0F; bus.b = 16'h0101; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({bus.busy, bus.done, bus.result, bus.zero, bus.err} !== {2'b00, 16'h0000, 2'b10}) begin
      errors++; $display("FAIL midop_reset: got busy %b done %b result %h zero %b err %b expected 0 0 0000 1 0",
                         bus.busy, bus.done, bus.result, bus.zero, bus.err);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL midop_no_done: got %0d done pulses expected 0", nd); end
    run_op(3'b000, 16'd7, 16'd3, lat, bc);
    checks++; if ({lat, bus.result} !== {32'sd5, 16'd10}) begin
      errors++; $display("FAIL midop_recover: got lat %0d result %h expected 5 000a", lat, bus.result);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.op = 3'b000;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_add();
    test_sub();
    test_overflow();
    test_logic();
    test_reserved();
    test_inflight();
    test_back_to_back();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
